// File: rtl/fas_peak_analyzer.sv
// FAS peak analyzer: scans a 16-bin FFT frame one bin per cycle and reports the strongest bin.
// Optional macro FAS_MAG_L1_EN selects |re|+|im| magnitude instead of re^2+im^2.

module fas_peak_mag #(
  parameter int DW = 16
) (
  input  logic [2*DW-1:0] bin,
  output logic [2*DW-1:0] mag
);
  logic signed [DW-1:0] re, im;
  assign re = bin[2*DW-1:DW];
  assign im = bin[DW-1:0];

`ifdef FAS_MAG_L1_EN
  localparam logic [DW-1:0] MINV = {1'b1, {(DW-1){1'b0}}};
  localparam logic [DW-1:0] MAXV = {1'b0, {(DW-1){1'b1}}};

  // The most-negative value has no positive twin; clamp it to the largest positive.
  function automatic logic [DW-1:0] abs_sat(input logic [DW-1:0] x);
    if (x == MINV)    return MAXV;
    else if (x[DW-1]) return ~x + DW'(1);
    else              return x;
  endfunction

  logic [DW-1:0] are, aim;
  assign are = abs_sat(re);
  assign aim = abs_sat(im);
  assign mag = {{DW{1'b0}}, are} + {{DW{1'b0}}, aim};
`else
  logic signed [2*DW-1:0] rex, imx, rr, ii;
  assign rex = (2*DW)'(re);
  assign imx = (2*DW)'(im);
  assign rr  = rex * rex;
  assign ii  = imx * imx;
  assign mag = $unsigned(rr) + $unsigned(ii);
`endif
endmodule

module fas_peak_analyzer #(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          fft_valid,
  input  logic [2*DW-1:0] fft_d0,
  input  logic [2*DW-1:0] fft_d1,
  input  logic [2*DW-1:0] fft_d2,
  input  logic [2*DW-1:0] fft_d3,
  input  logic [2*DW-1:0] fft_d4,
  input  logic [2*DW-1:0] fft_d5,
  input  logic [2*DW-1:0] fft_d6,
  input  logic [2*DW-1:0] fft_d7,
  input  logic [2*DW-1:0] fft_d8,
  input  logic [2*DW-1:0] fft_d9,
  input  logic [2*DW-1:0] fft_d10,
  input  logic [2*DW-1:0] fft_d11,
  input  logic [2*DW-1:0] fft_d12,
  input  logic [2*DW-1:0] fft_d13,
  input  logic [2*DW-1:0] fft_d14,
  input  logic [2*DW-1:0] fft_d15,
  output logic          done,
  output logic [3:0]    freq,
  output logic          busy,
  output logic          overrun
);
  localparam int NB = 16;
  localparam int BW = 2*DW;

  typedef enum logic {IDLE, SCAN} state_t;
  state_t state, state_nx;

  logic [NB-1:0][BW-1:0] din, work, shadow;
  logic [BW-1:0] best_mag, mag;
  logic [3:0]    best_idx, idx, win_idx;
  logic pending, pend_nx, last, take;
  logic load_in, load_sh, to_shadow, ovr_set, restart;

  assign din = {fft_d15, fft_d14, fft_d13, fft_d12, fft_d11, fft_d10, fft_d9, fft_d8,
                fft_d7,  fft_d6,  fft_d5,  fft_d4,  fft_d3,  fft_d2,  fft_d1, fft_d0};

  fas_peak_mag #(.DW(DW)) u_mag (.bin(work[idx]), .mag(mag));

  // Bin 0 always seeds the winner; strict compare keeps the lowest index on ties.
  assign last    = (state == SCAN) && (idx == 4'd15);
  assign take    = (idx == 4'd0) || (mag > best_mag);
  assign win_idx = take ? idx : best_idx;
  assign busy    = (state == SCAN) || pending;
  assign restart = load_in || load_sh;

  always_comb begin
    state_nx  = state;
    pend_nx   = pending;
    load_in   = 1'b0;
    load_sh   = 1'b0;
    to_shadow = 1'b0;
    ovr_set   = 1'b0;
    case (state)
      IDLE: begin
        if (fft_valid) begin
          load_in  = 1'b1;
          state_nx = SCAN;
        end
      end
      SCAN: begin
        if (last) begin
          if (pending) begin
            load_sh   = 1'b1;
            to_shadow = fft_valid;
            pend_nx   = fft_valid;
          end else if (fft_valid) begin
            load_in = 1'b1;
          end else begin
            state_nx = IDLE;
          end
        end else if (fft_valid) begin
          to_shadow = 1'b1;
          pend_nx   = 1'b1;
          ovr_set   = pending;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      pending  <= 1'b0;
      best_mag <= '0;
      best_idx <= '0;
      idx      <= '0;
      done     <= 1'b0;
      freq     <= '0;
      overrun  <= 1'b0;
    end else begin
      state   <= state_nx;
      pending <= pend_nx;
      done    <= last;
      if (ovr_set) overrun <= 1'b1;
      if (last)    freq    <= win_idx;
      if (restart) begin
        idx      <= '0;
        best_mag <= '0;
        best_idx <= '0;
      end else if (state == SCAN) begin
        idx <= idx + 4'd1;
        if (take) begin
          best_mag <= mag;
          best_idx <= idx;
        end
      end
    end
  end

  // Frame storage carries no reset; contents are only read after a load.
  always_ff @(posedge clk) begin
    if (load_in)      work <= din;
    else if (load_sh) work <= shadow;
    if (to_shadow) shadow <= din;
  end
endmodule

// File: tb/tb_fas_peak_analyzer.sv
// Randomized + directed bench for fas_peak_analyzer against a frame-level timeline model.
module tb_fas_peak_analyzer;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic fft_valid = 1'b0;
  logic [2*DW-1:0] d   [16];
  logic [2*DW-1:0] nxt [16];
  logic done, busy, overrun;
  logic [3:0] freq;

  int n_cmp = 0;
  int n_err = 0;

  // Model: frame-level view (active frame with its finish edge, one pending slot).
  int ec = 0;
  int m_end = 0;
  bit m_act = 0, m_pend = 0, m_ovr = 0, m_done = 0;
  logic [3:0] m_cur = 0, m_pnd = 0, m_freq = 0;

  always #5 clk = ~clk;

  fas_peak_analyzer #(.DW(DW)) dut (
    .clk(clk), .rst(rst), .fft_valid(fft_valid),
    .fft_d0(d[0]),   .fft_d1(d[1]),   .fft_d2(d[2]),   .fft_d3(d[3]),
    .fft_d4(d[4]),   .fft_d5(d[5]),   .fft_d6(d[6]),   .fft_d7(d[7]),
    .fft_d8(d[8]),   .fft_d9(d[9]),   .fft_d10(d[10]), .fft_d11(d[11]),
    .fft_d12(d[12]), .fft_d13(d[13]), .fft_d14(d[14]), .fft_d15(d[15]),
    .done(done), .freq(freq), .busy(busy), .overrun(overrun)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic longint ref_mag(input logic [31:0] w);
    longint re, im;
    re = longint'($signed(w[31:16]));
    im = longint'($signed(w[15:0]));
`ifdef FAS_MAG_L1_EN
    if (re < 0) re = -re;
    if (im < 0) im = -im;
    if (re > 32767) re = 32767;
    if (im > 32767) im = 32767;
    return re + im;
`else
    return re*re + im*im;
`endif
  endfunction

  // Largest magnitude, then the first bin that reaches it.
  function automatic logic [3:0] ref_peak();
    longint m [16];
    longint mx;
    logic [3:0] p;
    mx = 0;
    p = 0;
    for (int k = 0; k < 16; k++) begin
      m[k] = ref_mag(nxt[k]);
      if (m[k] > mx) mx = m[k];
    end
    for (int k = 15; k >= 0; k--) if (m[k] == mx) p = 4'(k);
    return p;
  endfunction

  task automatic model_edge(input bit v, input logic [3:0] pk);
    ec++;
    m_done = 0;
    if (m_act && ec == m_end) begin
      m_done = 1;
      m_freq = m_cur;
      if (m_pend) begin
        m_cur = m_pnd;
        m_end = ec + 16;
        if (v) m_pnd = pk; else m_pend = 0;
      end else if (v) begin
        m_cur = pk;
        m_end = ec + 16;
      end else m_act = 0;
    end else if (m_act) begin
      if (v) begin
        if (m_pend) m_ovr = 1;
        m_pnd  = pk;
        m_pend = 1;
      end
    end else if (v) begin
      m_act = 1;
      m_cur = pk;
      m_end = ec + 16;
    end
  endtask

  task automatic step(input bit v);
    @(negedge clk);
    chk("done", 32'(done), 32'(m_done));
    chk("freq", 32'(freq), 32'(m_freq));
    chk("busy", 32'(busy), 32'(m_act || m_pend));
    chk("overrun", 32'(overrun), 32'(m_ovr));
    fft_valid = v;
    for (int k = 0; k < 16; k++) d[k] = v ? nxt[k] : $urandom;
    model_edge(v, ref_peak());
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0);
  endtask

  task automatic clr();
    for (int k = 0; k < 16; k++) nxt[k] = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    fft_valid = 1'b0;
    #1;
    chk("rst_done", 32'(done), 0);
    chk("rst_freq", 32'(freq), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_overrun", 32'(overrun), 0);
    m_act = 0; m_pend = 0; m_ovr = 0; m_done = 0; m_freq = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    clr();
    for (int k = 0; k < 16; k++) d[k] = '0;
    do_reset();

    // Single frame, peak at bin 5
    clr(); nxt[5] = {16'h0300, 16'h0400};
    step(1); idle(20);
    chk("single_freq", 32'(freq), 5);

    // Tie in both magnitude flavours resolves to the lower bin
    clr(); nxt[3] = {16'h0200, 16'h0000}; nxt[9] = {16'h0200, 16'h0000};
    step(1); idle(18);
    chk("tie_freq", 32'(freq), 3);
    clr(); nxt[3] = {16'h0300, 16'h0400}; nxt[9] = {16'h0500, 16'h0000};
    step(1); idle(18);
    chk("tie2_freq", 32'(freq), 3);

    // Negative component
    clr(); nxt[12] = {16'hF000, 16'h0000}; nxt[2] = {16'h0100, 16'h0100};
    step(1); idle(18);
    chk("sign_freq", 32'(freq), 12);

    // All-zero frame
    clr();
    step(1); idle(18);
    chk("zero_freq", 32'(freq), 0);

    // Extreme values
    clr(); nxt[6] = {16'h8000, 16'h8000}; nxt[4] = {16'h7FFF, 16'h7FFF};
    step(1); idle(18);

    // Back-to-back frames
    clr(); nxt[7] = {16'h0100, 16'h0000};
    step(1); idle(15);
    clr(); nxt[1] = {16'h0000, 16'hFF00};
    step(1); idle(20);
    chk("b2b_freq", 32'(freq), 1);
    chk("b2b_ovr", 32'(overrun), 0);

    // Overrun: middle frame is dropped
    clr(); nxt[4] = {16'h0100, 16'h0000};
    step(1); idle(3);
    clr(); nxt[10] = {16'h0100, 16'h0000};
    step(1); idle(3);
    clr(); nxt[13] = {16'h0100, 16'h0000};
    step(1); idle(30);
    chk("ovr_freq", 32'(freq), 13);
    chk("ovr_flag", 32'(overrun), 1);

    // Reset mid-scan, then no stray done
    clr(); nxt[8] = {16'h0400, 16'h0000};
    step(1); idle(5);
    do_reset();
    idle(25);

    // Random traffic
    for (int c = 0; c < 1500; c++) begin
      for (int k = 0; k < 16; k++) begin
        case ($urandom_range(0, 7))
          0:       nxt[k] = 32'h8000_8000;
          1:       nxt[k] = '0;
          2:       nxt[k] = {16'($urandom_range(0, 3) << 8), 16'h0000};
          default: nxt[k] = $urandom;
        endcase
      end
      if ($urandom_range(0, 199) == 0) do_reset();
      else step($urandom_range(0, 9) < 2);
    end
    idle(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
